dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: core-won cycles a waiting debug request tolerates before debug gets priority.
REQ-002 SHALL have parameter ADDR_W, default 32: address width of both requester ports.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have core ports c_req/c_we (in,1), c_addr (in,ADDR_W), c_wdata (in,32), c_s_sel (in,2), c_ld_sel (in,3): core data request.
REQ-006 SHALL have core ports c_gnt, c_done, c_err, core_stall (out,1) and c_rdata (out,32): core response.
REQ-007 SHALL have debug ports d_req/d_we (in,1), d_addr (in,ADDR_W), d_wdata (in,32): word-only loader/debug request.
REQ-008 SHALL have debug ports d_gnt, d_done, d_err (out,1) and d_rdata (out,32): debug response.
REQ-009 SHALL have memory ports m_mem_write, m_mem_read (out,1), m_s_sel (out,2), m_ld_sel (out,3), m_addr (out,ADDR_W), m_wdata (out,32), m_rd_data (in,32): data-memory side.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-011 SHALL accept at most one request per cycle, in IDLE or RESP only; x_gnt is a combinational one-cycle pulse in the accept cycle, and the FSM goes to ACCESS.
REQ-012 SHALL require requesters to hold req and payload stable until gnt; payload is latched at the accept edge.
REQ-013 SHALL drive the memory in ACCESS only, from the latched payload: m_mem_write=we, m_mem_read=!we; both are 0 in all other states.
REQ-014 SHALL force debug transactions to m_s_sel=2'b10 and m_ld_sel=3'b010 (word); core transactions pass c_s_sel/c_ld_sel through.
REQ-015 SHALL register m_rd_data at the end of ACCESS and, in RESP, pulse owner's x_done for one cycle with x_rdata valid (0 for writes); latency from gnt to done is exactly 2 cycles.
REQ-016 SHALL exit RESP to ACCESS if a new request is accepted, else to IDLE; sustained throughput is one transaction per 2 cycles.
REQ-017 SHALL arbitrate with fixed core priority, except that debug wins when starve count >= STARVE_LIMIT.
REQ-018 SHALL increment the starve count (saturating at STARVE_LIMIT) each accept cycle where d_req=1 and the core is granted, and clear it on d_gnt.
REQ-019 SHALL drive core_stall = c_req & !c_done combinationally.
REQ-020 SHALL hold x_rdata stable between done pulses.

Reset
REQ-021 SHALL, while reset=1, place the FSM in IDLE, clear the starve count and rdata registers, and drive every output 0.
REQ-022 SHALL gate m_mem_write and m_mem_read with !reset, so a reset in ACCESS aborts the transaction with no memory write; no done pulse is produced.

Configuration
REQ-023 SHALL, with DMEM_ARB_ADDR_CHECK_EN defined, flag a latched address with addr[ADDR_W-1:10] != 0 as out-of-range: memory strobes stay 0 in ACCESS, the RESP cycle pulses x_done and x_err, and x_rdata=0.
REQ-024 SHALL, without DMEM_ARB_ADDR_CHECK_EN, forward all addresses unchecked and tie c_err/d_err to 0.

Structure
REQ-025 SHALL place the FSM state enum, owner encoding (OWN_CORE, OWN_DBG), S_SEL_WORD=2'b10, LD_SEL_WORD=3'b010 and MEM_WORDS=256 in shared package dmem_arb_pkg.
REQ-026 SHALL implement the saturating starve counter as sub-module dmem_arb_starve_cnt (inputs inc, clr; output limit_hit).

Verification
REQ-027 SHALL cover a core sw: 0x7 at 0x0 via c_s_sel=10, then lw via c_ld_sel=010 -> done 2 cycles after each gnt, c_rdata=0x7, m_mem_write high exactly one cycle.
REQ-028 SHALL cover simultaneous c_req and d_req with STARVE_LIMIT=4 and the core requesting continuously -> core granted 4 times, then d_gnt; starve count then cleared.
REQ-029 SHALL cover a debug write of 0x201 to 0x10 -> m_s_sel=10 regardless of core state; a later core lw of 0x10 returns 0x201.
REQ-030 SHALL cover back-to-back core reads of 0x0 and 0x4 -> gnt in cycles N and N+2, done in N+2 and N+4, core_stall high between.
REQ-031 SHALL cover reset asserted during the ACCESS cycle of a sw -> target memory word unchanged, no c_done, FSM in IDLE.
REQ-032 SHALL cover (DMEM_ARB_ADDR_CHECK_EN) a core lw at 0x400 -> c_err and c_done together, c_rdata=0, m_mem_read never asserted.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DBG  = 1'b1
   } owner_e;

   localparam logic [1:0] S_SEL_WORD  = 2'b10;
   localparam logic [2:0] LD_SEL_WORD = 3'b010;
   localparam int         MEM_WORDS   = 256;
   // Lowest byte-address bit that lies beyond the data memory.
   localparam int         OOR_LSB     = $clog2(MEM_WORDS * 4);

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of accepts the core won while debug was waiting.
// Latency: limit_hit reflects the count registered at the previous edge.
// Backpressure: none; inc is ignored once the limit is reached, clr wins.
module dmem_arb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign limit_hit = (cnt_q >= LIMIT);

   // Next count: clear on a debug grant, otherwise count up until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !limit_hit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core, debug) arbiter in front of a single-ported data memory.
// Latency: grant to done is 2 cycles; one transaction every 2 cycles sustained.
// Backpressure: requesters hold req/payload until their combinational gnt pulse.
// Optional build macro DMEM_ARB_ADDR_CHECK_EN enables out-of-range address errors.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   input  logic [1:0]        c_s_sel,
   input  logic [2:0]        c_ld_sel,
   output logic              c_gnt,
   output logic              c_done,
   output logic              c_err,
   output logic              core_stall,
   output logic [31:0]       c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic              d_err,
   output logic [31:0]       d_rdata,
   output logic              m_mem_write,
   output logic              m_mem_read,
   output logic [1:0]        m_s_sel,
   output logic [2:0]        m_ld_sel,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rd_data
);

   import dmem_arb_pkg::*;

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        s_sel_q, s_sel_d;
   logic [2:0]        ld_sel_q, ld_sel_d;
   logic [31:0]       c_rdata_q, c_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;

   logic        limit_hit;
   logic        accept_ok, dbg_win, in_acc, in_resp, addr_bad;
   logic [31:0] rd_val;

`ifdef DMEM_ARB_ADDR_CHECK_EN
   assign addr_bad = |addr_q[ADDR_W-1:OOR_LSB];
`else
   assign addr_bad = 1'b0;
`endif

   // Debug wins when it is alone or has been starved long enough.
   assign accept_ok = (state_q != ACCESS) && !reset;
   assign dbg_win   = d_req && (limit_hit || !c_req);
   assign c_gnt     = accept_ok && c_req && !dbg_win;
   assign d_gnt     = accept_ok && dbg_win;

   assign in_acc  = (state_q == ACCESS) && !reset;
   assign in_resp = (state_q == RESP) && !reset;

   // Writes and rejected addresses report zero read data.
   assign rd_val = (we_q || addr_bad) ? 32'h0 : m_rd_data;

   assign m_mem_write = in_acc && we_q && !addr_bad;
   assign m_mem_read  = in_acc && !we_q && !addr_bad;
   assign m_s_sel     = in_acc ? s_sel_q  : 2'b00;
   assign m_ld_sel    = in_acc ? ld_sel_q : 3'b000;
   assign m_addr      = in_acc ? addr_q   : '0;
   assign m_wdata     = in_acc ? wdata_q  : 32'h0;

   assign c_done     = in_resp && (owner_q == OWN_CORE);
   assign d_done     = in_resp && (owner_q == OWN_DBG);
   assign c_err      = c_done && addr_bad;
   assign d_err      = d_done && addr_bad;
   assign c_rdata    = reset ? 32'h0 : c_rdata_q;
   assign d_rdata    = reset ? 32'h0 : d_rdata_q;
   assign core_stall = c_req && !c_done && !reset;

   dmem_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .inc       (c_gnt && d_req),
      .clr       (d_gnt),
      .limit_hit (limit_hit)
   );

   // FSM sequencing, payload capture on accept, read-data capture at end of ACCESS.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      s_sel_d   = s_sel_q;
      ld_sel_d  = ld_sel_q;
      c_rdata_d = c_rdata_q;
      d_rdata_d = d_rdata_q;

      case (state_q)
         IDLE:    if (c_gnt || d_gnt) state_d = ACCESS;
         ACCESS: begin
            state_d = RESP;
            if (owner_q == OWN_CORE) c_rdata_d = rd_val;
            else                     d_rdata_d = rd_val;
         end
         RESP:    state_d = (c_gnt || d_gnt) ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase

      if (c_gnt) begin
         owner_d  = OWN_CORE;
         we_d     = c_we;
         addr_d   = c_addr;
         wdata_d  = c_wdata;
         s_sel_d  = c_s_sel;
         ld_sel_d = c_ld_sel;
      end else if (d_gnt) begin
         owner_d  = OWN_DBG;
         we_d     = d_we;
         addr_d   = d_addr;
         wdata_d  = d_wdata;
         s_sel_d  = S_SEL_WORD;
         ld_sel_d = LD_SEL_WORD;
      end
   end

   // State and payload registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_CORE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         s_sel_q   <= 2'b00;
         ld_sel_q  <= 3'b000;
         c_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         s_sel_q   <= s_sel_d;
         ld_sel_q  <= ld_sel_d;
         c_rdata_q <= c_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-wide behavioural data memory.
// Latency: checks are sampled 1-2 ns after each rising edge.
// Backpressure: requests are held until gnt, then dropped or replaced.
module tb_dmem_arbiter;

   import dmem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic [1:0]  c_s_sel;
   logic [2:0]  c_ld_sel;
   logic        c_gnt, c_done, c_err, core_stall, d_gnt, d_done, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic        m_mem_write, m_mem_read;
   logic [1:0]  m_s_sel;
   logic [2:0]  m_ld_sel;
   logic [31:0] m_addr, m_wdata, m_rd_data;

   logic [31:0] mem [MEM_WORDS];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_s_sel(c_s_sel), .c_ld_sel(c_ld_sel),
      .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .core_stall(core_stall), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .m_mem_write(m_mem_write), .m_mem_read(m_mem_read), .m_s_sel(m_s_sel),
      .m_ld_sel(m_ld_sel), .m_addr(m_addr), .m_wdata(m_wdata), .m_rd_data(m_rd_data)
   );

   // Behavioural word memory: combinational read, write on the rising edge.
   assign m_rd_data = mem[m_addr[9:2]];
   always @(posedge clk) begin
      if (m_mem_write) begin
         mem[m_addr[9:2]] <= m_wdata;
         wr_cnt++;
      end
      if (m_mem_read) rd_cnt++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One core transaction, request dropped right after the grant.
   task automatic core_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input string nm);
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
      #1;
      total_cnt++;
      if (c_gnt !== 1'b1) $display("FAIL %s gnt: got %b want 1", nm, c_gnt); else pass_cnt++;
      cyc();
      c_req = 1'b0;
      #1;
      total_cnt++;
      if (m_mem_write !== we || m_mem_read !== !we || m_s_sel !== c_s_sel || c_done !== 1'b0)
         $display("FAIL %s access: wr=%b rd=%b s_sel=%b done=%b want wr=%b rd=%b s_sel=%b done=0",
                  nm, m_mem_write, m_mem_read, m_s_sel, c_done, we, !we, c_s_sel);
      else pass_cnt++;
      cyc();
      #1;
      total_cnt++;
      if (c_done !== 1'b1 || c_err !== 1'b0 || c_rdata !== exp_rdata)
         $display("FAIL %s resp: done=%b err=%b rdata=%h want 1 0 %h", nm, c_done, c_err, c_rdata, exp_rdata);
      else pass_cnt++;
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
      c_s_sel = S_SEL_WORD; c_ld_sel = LD_SEL_WORD;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h0;
      cyc(); cyc();
      #1;
      total_cnt++;
      if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || core_stall !== 1'b0 || c_done !== 1'b0 || d_done !== 1'b0)
         $display("FAIL reset_ctrl: gnt=%b/%b stall=%b done=%b/%b want all 0", c_gnt, d_gnt, core_stall, c_done, d_done);
      else pass_cnt++;
      total_cnt++;
      if (m_mem_write !== 1'b0 || m_mem_read !== 1'b0 || c_rdata !== 32'h0 || d_rdata !== 32'h0 || m_addr !== 32'h0)
         $display("FAIL reset_data: wr=%b rd=%b c_rdata=%h d_rdata=%h m_addr=%h want all 0",
                  m_mem_write, m_mem_read, c_rdata, d_rdata, m_addr);
      else pass_cnt++;
      c_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_sw_lw();
      int w0;
      w0 = wr_cnt;
      core_txn(1'b1, 32'h0, 32'h7, 32'h0, "sw0");
      total_cnt++;
      if (wr_cnt - w0 !== 1 || mem[0] !== 32'h7)
         $display("FAIL sw_write_count: writes=%0d mem0=%h want 1 00000007", wr_cnt - w0, mem[0]);
      else pass_cnt++;
      core_txn(1'b0, 32'h0, 32'h0, 32'h7, "lw0");
   endtask

   task automatic test_starve();
      logic exp_c, exp_d;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      // Accepts land on even cycles: core 4 times, then debug, then core again.
      for (int k = 0; k <= 10; k++) begin
         #1;
         exp_c = (k % 2 == 0) && (k != 8);
         exp_d = (k == 8);
         total_cnt++;
         if (c_gnt !== exp_c || d_gnt !== exp_d)
            $display("FAIL starve_gnt_k%0d: c_gnt=%b d_gnt=%b want %b %b", k, c_gnt, d_gnt, exp_c, exp_d);
         else pass_cnt++;
         if (k == 10) begin
            total_cnt++;
            if (d_done !== 1'b1 || c_done !== 1'b0 || d_rdata !== 32'h0)
               $display("FAIL starve_dbg_done: d_done=%b c_done=%b d_rdata=%h want 1 0 0", d_done, c_done, d_rdata);
            else pass_cnt++;
         end
         cyc();
      end
      c_req = 1'b0; d_req = 1'b0;
      cyc();
      #1;
      total_cnt++;
      if (c_done !== 1'b1 || c_rdata !== 32'h7)
         $display("FAIL starve_tail_done: c_done=%b c_rdata=%h want 1 00000007", c_done, c_rdata);
      else pass_cnt++;
      cyc();
   endtask

   task automatic test_dbg_write();
      c_s_sel = 2'b01; c_ld_sel = 3'b100;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h201;
      #1;
      total_cnt++;
      if (d_gnt !== 1'b1 || c_gnt !== 1'b0) $display("FAIL dbg_gnt: d_gnt=%b c_gnt=%b want 1 0", d_gnt, c_gnt);
      else pass_cnt++;
      cyc();
      d_req = 1'b0;
      #1;
      total_cnt++;
      if (m_mem_write !== 1'b1 || m_s_sel !== 2'b10 || m_ld_sel !== 3'b010 || m_addr !== 32'h10 || m_wdata !== 32'h201)
         $display("FAIL dbg_access: wr=%b s_sel=%b ld_sel=%b addr=%h wdata=%h want 1 10 010 10 201",
                  m_mem_write, m_s_sel, m_ld_sel, m_addr, m_wdata);
      else pass_cnt++;
      cyc();
      #1;
      total_cnt++;
      if (d_done !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0)
         $display("FAIL dbg_done: d_done=%b d_err=%b d_rdata=%h want 1 0 0", d_done, d_err, d_rdata);
      else pass_cnt++;
      cyc();
      c_s_sel = S_SEL_WORD; c_ld_sel = LD_SEL_WORD;
      core_txn(1'b0, 32'h10, 32'h0, 32'h201, "lw10");
   endtask

   task automatic test_back_to_back();
      mem[1] = 32'h55;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0;
      #1;
      total_cnt++;
      if (c_gnt !== 1'b1) $display("FAIL b2b_gnt_n: got %b want 1", c_gnt); else pass_cnt++;
      cyc();
      c_addr = 32'h4;
      #1;
      total_cnt++;
      if (c_gnt !== 1'b0 || core_stall !== 1'b1) $display("FAIL b2b_n1: gnt=%b stall=%b want 0 1", c_gnt, core_stall);
      else pass_cnt++;
      cyc();
      #1;
      total_cnt++;
      if (c_gnt !== 1'b1 || c_done !== 1'b1 || core_stall !== 1'b0 || c_rdata !== 32'h7)
         $display("FAIL b2b_n2: gnt=%b done=%b stall=%b rdata=%h want 1 1 0 00000007", c_gnt, c_done, core_stall, c_rdata);
      else pass_cnt++;
      cyc();
      #1;
      total_cnt++;
      if (core_stall !== 1'b1 || c_done !== 1'b0 || c_rdata !== 32'h7)
         $display("FAIL b2b_n3: stall=%b done=%b rdata=%h want 1 0 00000007", core_stall, c_done, c_rdata);
      else pass_cnt++;
      cyc();
      c_req = 1'b0;
      #1;
      total_cnt++;
      if (c_done !== 1'b1 || c_rdata !== 32'h55 || c_gnt !== 1'b0)
         $display("FAIL b2b_n4: done=%b rdata=%h gnt=%b want 1 00000055 0", c_done, c_rdata, c_gnt);
      else pass_cnt++;
      cyc();
   endtask

   task automatic test_reset_abort();
      int w0;
      w0 = wr_cnt;
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h8; c_wdata = 32'hdead;
      #1;
      total_cnt++;
      if (c_gnt !== 1'b1) $display("FAIL abort_gnt: got %b want 1", c_gnt); else pass_cnt++;
      cyc();
      c_req = 1'b0; reset = 1'b1;
      #1;
      total_cnt++;
      if (m_mem_write !== 1'b0) $display("FAIL abort_strobe: m_mem_write=%b want 0", m_mem_write); else pass_cnt++;
      cyc();
      reset = 1'b0;
      #1;
      total_cnt++;
      if (c_done !== 1'b0 || dut.state_q !== IDLE)
         $display("FAIL abort_state: c_done=%b state=%0d want 0 %0d", c_done, dut.state_q, IDLE);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (mem[2] !== 32'h0 || wr_cnt !== w0)
         $display("FAIL abort_mem: mem2=%h writes=%0d want 0 %0d", mem[2], wr_cnt, w0);
      else pass_cnt++;
   endtask

   task automatic test_addr_check();
      int r0;
      r0 = rd_cnt;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h400;
      cyc();
      c_req = 1'b0;
      cyc();
      #1;
`ifdef DMEM_ARB_ADDR_CHECK_EN
      total_cnt++;
      if (c_done !== 1'b1 || c_err !== 1'b1 || c_rdata !== 32'h0 || rd_cnt !== r0)
         $display("FAIL addr_oor: done=%b err=%b rdata=%h reads=%0d want 1 1 0 %0d", c_done, c_err, c_rdata, rd_cnt, r0);
      else pass_cnt++;
`else
      // Unchecked build: 0x400 aliases word 0 in the 256-word memory.
      total_cnt++;
      if (c_done !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'h7 || rd_cnt !== r0 + 1)
         $display("FAIL addr_fwd: done=%b err=%b rdata=%h reads=%0d want 1 0 00000007 %0d", c_done, c_err, c_rdata, rd_cnt, r0 + 1);
      else pass_cnt++;
`endif
      cyc();
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
      test_reset();
      test_sw_lw();
      test_starve();
      test_dbg_write();
      test_back_to_back();
      test_reset_abort();
      test_addr_check();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
